// File: rtl/chaotic_state_feedback.sv
// chaotic_state_feedback: closes the x/y/z Euler-stage loop and emits one sequence bit per iteration.
// Define CHAOS_FB_TIMEOUT_EN to bound the time spent waiting for stage results.
module chaotic_state_feedback #(
  parameter int DATA_WIDTH  = 64,
  parameter int ITER_WIDTH  = 32,
  parameter int QBIT        = 20,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] iter_num,
  input  logic [DATA_WIDTH-1:0] seed_x,
  input  logic [DATA_WIDTH-1:0] seed_y,
  input  logic [DATA_WIDTH-1:0] seed_z,
  input  logic                  xn1_valid,
  input  logic [DATA_WIDTH-1:0] xn1,
  input  logic                  yn1_valid,
  input  logic [DATA_WIDTH-1:0] yn1,
  input  logic                  zn1_valid,
  input  logic [DATA_WIDTH-1:0] zn1,
  output logic                  xn_valid,
  output logic [DATA_WIDTH-1:0] xn,
  output logic                  yn_valid,
  output logic [DATA_WIDTH-1:0] yn,
  output logic                  zn_valid,
  output logic [DATA_WIDTH-1:0] zn,
  output logic                  bit_valid,
  output logic                  bit_out,
  output logic [ITER_WIDTH-1:0] iter_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, SEED, WAIT, ISSUE, FIN} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] hx, hy, hz, nx, ny, nz;
  logic                  fx, fy, fz, all_in, timeout;
  logic [ITER_WIDTH-1:0] lim, cnt_nxt;
  // results arriving this cycle count toward completion and feed the re-issue directly
  always_comb begin
    nx      = fx ? hx : xn1;
    ny      = fy ? hy : yn1;
    nz      = fz ? hz : zn1;
    all_in  = (fx | xn1_valid) & (fy | yn1_valid) & (fz | zn1_valid);
    cnt_nxt = iter_cnt + 1'b1;
  end
`ifdef CHAOS_FB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else        wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
  always_comb timeout = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  always_comb timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xn_valid  <= 1'b0;
      yn_valid  <= 1'b0;
      zn_valid  <= 1'b0;
      xn        <= '0;
      yn        <= '0;
      zn        <= '0;
      hx        <= '0;
      hy        <= '0;
      hz        <= '0;
      fx        <= 1'b0;
      fy        <= 1'b0;
      fz        <= 1'b0;
      lim       <= '0;
      iter_cnt  <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      xn_valid  <= 1'b0;
      yn_valid  <= 1'b0;
      zn_valid  <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          lim      <= iter_num;
          iter_cnt <= '0;
          err      <= 1'b0;
          fx       <= 1'b0;
          fy       <= 1'b0;
          fz       <= 1'b0;
          busy     <= 1'b1;
          if (iter_num == '0) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state    <= SEED;
            xn       <= seed_x;
            yn       <= seed_y;
            zn       <= seed_z;
            xn_valid <= 1'b1;
            yn_valid <= 1'b1;
            zn_valid <= 1'b1;
          end
        end
        SEED: state <= WAIT;
        WAIT: begin
          // a repeat result keeps the first value and flags the protocol error
          if (xn1_valid) begin
            if (fx) err <= 1'b1;
            else begin hx <= xn1; fx <= 1'b1; end
          end
          if (yn1_valid) begin
            if (fy) err <= 1'b1;
            else begin hy <= yn1; fy <= 1'b1; end
          end
          if (zn1_valid) begin
            if (fz) err <= 1'b1;
            else begin hz <= zn1; fz <= 1'b1; end
          end
          if (all_in) begin
            iter_cnt  <= cnt_nxt;
            bit_valid <= 1'b1;
            bit_out   <= nx[QBIT];
            if (cnt_nxt == lim) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= ISSUE;
              xn       <= nx;
              yn       <= ny;
              zn       <= nz;
              xn_valid <= 1'b1;
              yn_valid <= 1'b1;
              zn_valid <= 1'b1;
            end
          end else if (timeout) begin
            err   <= 1'b1;
            state <= FIN;
            done  <= 1'b1;
          end
        end
        ISSUE: begin
          fx    <= 1'b0;
          fy    <= 1'b0;
          fz    <= 1'b0;
          state <= WAIT;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/chaotic_state_feedback.md
# chaotic_state_feedback

Iteration controller that closes the loop around the three forward-Euler chaotic-equation stages (x, y, z). It seeds the stages with initial state, collects xn1/yn1/zn1 results that arrive with independent latencies, and re-issues the complete (xn, yn, zn) state as one aligned valid pulse once all three are present. For each completed iteration it emits one quantised sequence bit taken from the new x value, which feeds the M-sequence output path.

## Interface
Parameters:
- DATA_WIDTH, 64, float64 word width; must match the Floating-point IP width.
- ITER_WIDTH, 32, width of the iteration counter and limit.
- QBIT, 20, bit index of xn1 taken as the sequence bit (0 ≤ QBIT < DATA_WIDTH).
- TIMEOUT_CYC, 1023, maximum cycles spent in WAIT (used only with the timeout macro).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- iter_num  in  ITER_WIDTH  number of iterations to run; sampled on start.
- seed_x / seed_y / seed_z  in  DATA_WIDTH each  initial state; sampled on start.
- xn1_valid, xn1 / yn1_valid, yn1 / zn1_valid, zn1  in  1 + DATA_WIDTH each  results from the equation stages.
- xn_valid, xn / yn_valid, yn / zn_valid, zn  out  1 + DATA_WIDTH each  state to the equation stages. All three valids are always identical.
- bit_valid  out  1  one-cycle pulse per completed iteration.
- bit_out  out  1  sequence bit, equal to xn1[QBIT] of that iteration.
- iter_cnt  out  ITER_WIDTH  completed iterations in the current run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  sticky error flag; cleared by start or by reset.

## Operation
- States: IDLE, SEED, WAIT, ISSUE, FIN.
- IDLE:
  - On start, latch the seeds and iter_num, clear iter_cnt, the capture flags and err.
  - Go to SEED, or to FIN if iter_num == 0.
  - start received in any other state is ignored.
- SEED:
  - Drive the seeds on xn/yn/zn with all three valids high for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - Each xn1/yn1/zn1 with its valid high is captured into a holding register and sets that variable's flag.
  - Any subset may arrive in the same cycle.
  - A valid for a variable whose flag is already set is dropped: the holding register keeps its first value and err is set.
  - When all three flags are set (counting captures made in the current cycle), iter_cnt increments on the next edge.
  - Then go to FIN if the new iter_cnt == iter_num, otherwise go to ISSUE.
- ISSUE:
  - Drive the held values on xn/yn/zn with valids high for one cycle.
  - Clear the flags and return to WAIT.
- bit_valid/bit_out are registered on the same edge that increments iter_cnt. This happens in both the ISSUE and FIN branches.
- FIN: done pulses for one cycle, then go to IDLE.
  - xn/yn/zn keep the last issued state.
  - iter_cnt holds its value until the next start.
- Result valids that arrive in IDLE, SEED, ISSUE or FIN are ignored and do not set err.
- All arithmetic is unsigned modulo 2^ITER_WIDTH. Data words are passed through untouched, with no float interpretation.

## Timing
- Reset values:
  - All valids, bit_valid, bit_out, busy, done and err are 0.
  - xn, yn, zn and iter_cnt are 0.
  - State is IDLE.
- All outputs are registered.
- start at edge T → seed valids high during cycle T+1.
- Last result sampled at edge N:
  - Next-state valids high during cycle N+1.
  - bit_valid high during cycle N+1.
- Loop overhead is 2 cycles beyond the equation-stage latency.
- Reset asserted mid-run returns to IDLE immediately. No done pulse is generated.

## Configuration
- CHAOS_FB_TIMEOUT_EN defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYC before all three flags are set, err is set and the FSM goes to FIN.
  - done pulses and iter_cnt keeps its count.
- CHAOS_FB_TIMEOUT_EN undefined: no counter exists and WAIT can last indefinitely.

## Test plan
- Zero-length run: start with iter_num=0 → done pulses at T+1. No xn_valid and no bit_valid; busy is high for 1 cycle.
- Seed issue: seeds 0x3FF0000000000000 / 0x4000000000000000 / 0x4008000000000000, iter_num=1 → all three valids high for 1 cycle at T+1 with those values.
  - Return xn1=0x0000000000100000, yn1 and zn1 together 30 cycles later → bit_valid with bit_out=1, done and iter_cnt=1, with no re-issue.
- Skewed arrival: zn1 at +10, xn1 at +20, yn1 at +35 → re-issue occurs exactly 1 cycle after the yn1 edge with the captured values. iter_num=3 yields 3 bit_valid pulses, then done.
- Duplicate valid: xn1_valid pulsed twice (values A then B) before yn1 arrives → err=1 and the issued xn equals A.
- Reset mid-run: rst_n low during WAIT of iteration 2 → all outputs 0 immediately and no done. A subsequent start runs normally with err=0.
- Timeout (macro defined, TIMEOUT_CYC=16): withhold zn1 → err=1 and done after 16 WAIT cycles, with iter_cnt unchanged. With the macro undefined, busy stays high indefinitely.
